// File: rtl/mmss_timer_core_if.sv
// Button-bank inputs and mm:ss display outputs of mmss_timer_core.
// master = button/debounce side, slave = timer core.
interface mmss_timer_core_if;
   logic       mode_sw;
   logic       start;
   logic       stop;
   logic       softrst;
   logic       inc_min;
   logic       inc_sec;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       running;
   logic       blink;

   modport master (
      output mode_sw, start, stop, softrst, inc_min, inc_sec,
      input  minutes, seconds, running, blink
   );

   modport slave (
      input  mode_sw, start, stop, softrst, inc_min, inc_sec,
      output minutes, seconds, running, blink
   );
endinterface

// File: rtl/mmss_timer_core.sv
// mm:ss stopwatch / countdown core; button actions land one clk after their rising edge.
// Define AUTO_REPEAT_EN to add hold-to-repeat on inc_min/inc_sec.
module mmss_timer_core #(
   parameter int unsigned TICK_DIV   = 100_000_000,
   parameter int unsigned REPEAT_DLY = 50_000_000,
   parameter int unsigned REPEAT_DIV = 10_000_000
) (
   input  logic             clk,
   input  logic             rst,
   mmss_timer_core_if.slave bus
);
   localparam int unsigned   PW         = $clog2(TICK_DIV + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   if (TICK_DIV < 1 || REPEAT_DLY < 1 || REPEAT_DIV < 1) begin : g_bad_param
      $error("mmss_timer_core: TICK_DIV, REPEAT_DLY and REPEAT_DIV must be non-zero");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_PAUSED  = 2'd2,
      S_EXPIRED = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [5:0]    min_q, min_d;
   logic [5:0]    sec_q, sec_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          running_q, running_d;
   logic          blink_q, blink_d;

   logic start_q, stop_q, softrst_q, inc_min_q, inc_sec_q, mode_q;

   logic start_e, stop_e, softrst_e, inc_min_e, inc_sec_e, mode_chg;
   logic tick, start_ok;
   logic min_rpt, sec_rpt;
   logic inc_min_go, inc_sec_go;

   assign start_e   = bus.start   & ~start_q;
   assign stop_e    = bus.stop    & ~stop_q;
   assign softrst_e = bus.softrst & ~softrst_q;
   assign inc_min_e = bus.inc_min & ~inc_min_q;
   assign inc_sec_e = bus.inc_sec & ~inc_sec_q;
   assign mode_chg  = bus.mode_sw ^ mode_q;

   assign tick = (state_q == S_RUN) && (presc_q == PRESC_LAST);

   // A countdown cannot start from 00:00, a stopwatch cannot start from 59:59.
   assign start_ok = mode_q ? ((min_q != 6'd0) || (sec_q != 6'd0))
                            : !((min_q == 6'd59) && (sec_q == 6'd59));

   assign inc_min_go = inc_min_e | min_rpt;
   assign inc_sec_go = inc_sec_e | sec_rpt;

`ifdef AUTO_REPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DLY > REPEAT_DIV) ? REPEAT_DLY : REPEAT_DIV;
   localparam int unsigned RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] R_DLY = RW'(REPEAT_DLY);
   localparam logic [RW-1:0] R_DIV = RW'(REPEAT_DIV);

   logic          edit_ok;
   logic [RW-1:0] rmin_cnt_q, rmin_cnt_d, rsec_cnt_q, rsec_cnt_d;
   logic          rmin_arm_q, rmin_arm_d, rsec_arm_q, rsec_arm_d;

   assign edit_ok = (state_q == S_IDLE) || (state_q == S_PAUSED);

   // Count 0 means idle; an honoured edge loads 1, first repeat at REPEAT_DLY, then every REPEAT_DIV.
   always_comb begin
      rmin_cnt_d = '0;
      rmin_arm_d = 1'b0;
      rsec_cnt_d = '0;
      rsec_arm_d = 1'b0;
      min_rpt    = 1'b0;
      sec_rpt    = 1'b0;
      if (edit_ok && bus.inc_min) begin
         if (inc_min_e) begin
            rmin_cnt_d = RW'(1);
         end else if (rmin_cnt_q != '0) begin
            if (rmin_cnt_q == (rmin_arm_q ? R_DIV : R_DLY)) begin
               min_rpt    = 1'b1;
               rmin_cnt_d = RW'(1);
               rmin_arm_d = 1'b1;
            end else begin
               rmin_cnt_d = rmin_cnt_q + 1'b1;
               rmin_arm_d = rmin_arm_q;
            end
         end
      end
      if (edit_ok && bus.inc_sec) begin
         if (inc_sec_e) begin
            rsec_cnt_d = RW'(1);
         end else if (bus.inc_min) begin
            rsec_cnt_d = rsec_cnt_q;
            rsec_arm_d = rsec_arm_q;
         end else if (rsec_cnt_q != '0) begin
            if (rsec_cnt_q == (rsec_arm_q ? R_DIV : R_DLY)) begin
               sec_rpt    = 1'b1;
               rsec_cnt_d = RW'(1);
               rsec_arm_d = 1'b1;
            end else begin
               rsec_cnt_d = rsec_cnt_q + 1'b1;
               rsec_arm_d = rsec_arm_q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rmin_cnt_q <= '0;
         rmin_arm_q <= 1'b0;
         rsec_cnt_q <= '0;
         rsec_arm_q <= 1'b0;
      end else begin
         rmin_cnt_q <= rmin_cnt_d;
         rmin_arm_q <= rmin_arm_d;
         rsec_cnt_q <= rsec_cnt_d;
         rsec_arm_q <= rsec_arm_d;
      end
   end
`else
   assign min_rpt = 1'b0;
   assign sec_rpt = 1'b0;
`endif

   // Prescaler defaults to zero, so it only advances while RUN persists and restarts on every entry.
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      presc_d = '0;
      if (softrst_e || mode_chg) begin
         state_d = S_IDLE;
         min_d   = 6'd0;
         sec_d   = 6'd0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (stop_e) begin
                  state_d = S_PAUSED;
               end else if (tick) begin
                  if (mode_q) begin
                     if (sec_q == 6'd0) begin
                        sec_d = 6'd59;
                        min_d = min_q - 6'd1;
                     end else begin
                        sec_d = sec_q - 6'd1;
                     end
                     if ((min_q == 6'd0) && (sec_q == 6'd1)) begin
                        state_d = S_EXPIRED;
                     end
                  end else begin
                     if (sec_q == 6'd59) begin
                        sec_d = 6'd0;
                        min_d = min_q + 6'd1;
                     end else begin
                        sec_d = sec_q + 6'd1;
                     end
                     if ((min_q == 6'd59) && (sec_q == 6'd58)) begin
                        state_d = S_PAUSED;
                     end
                  end
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
            S_EXPIRED: begin
               if (start_e && !stop_e) begin
                  state_d = S_IDLE;
                  min_d   = 6'd0;
                  sec_d   = 6'd0;
               end
            end
            default: begin
               // IDLE / PAUSED: a stop edge masks start and the increments in the same cycle.
               if (!stop_e) begin
                  if (start_e) begin
                     if (start_ok) begin
                        state_d = S_RUN;
                     end
                  end else if (inc_min_go) begin
                     min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                  end else if (inc_sec_go) begin
                     sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                  end
               end
            end
         endcase
      end
      running_d = (state_d == S_RUN);
      blink_d   = (state_d == S_EXPIRED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         min_q     <= 6'd0;
         sec_q     <= 6'd0;
         presc_q   <= '0;
         running_q <= 1'b0;
         blink_q   <= 1'b0;
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         softrst_q <= 1'b0;
         inc_min_q <= 1'b0;
         inc_sec_q <= 1'b0;
         // Track the switch through reset so its level at release is not seen as a change.
         mode_q    <= bus.mode_sw;
      end else begin
         state_q   <= state_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         presc_q   <= presc_d;
         running_q <= running_d;
         blink_q   <= blink_d;
         start_q   <= bus.start;
         stop_q    <= bus.stop;
         softrst_q <= bus.softrst;
         inc_min_q <= bus.inc_min;
         inc_sec_q <= bus.inc_sec;
         mode_q    <= bus.mode_sw;
      end
   end

   assign bus.minutes = min_q;
   assign bus.seconds = sec_q;
   assign bus.running = running_q;
   assign bus.blink   = blink_q;
endmodule
